// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
//
// Purpose:
//   Deserializes asynchronous serial frames (start, DATA_BITS data bits LSB first,
//   one stop bit). A local bit-timing counter restarts on every start-bit edge and
//   is offset by half a bit period, so every bit is sampled at mid-bit.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   rx_serial  in   asynchronous serial line, idle high
//   rx_data    out  last correctly framed byte, LSB = first received bit
//   rx_valid   out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   busy       out  high whenever the receiver is not idle

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 busy_q;

  // Synchronized line; every decision below looks only at this.
  logic rxs;
  assign rxs = sync2_q;

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= rx_serial;
      sync2_q     <= sync1_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        // Half-bit wait: confirms the start bit and aligns the counter to mid-bit.
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Right shift: the first bit received ends up in the LSB.
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Leaving at mid-stop lets a start edge half a bit later be caught.
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxs) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // A held-low line reports one framing error, then waits for idle.
        BREAK: begin
          cnt_q <= '0;
          if (rxs) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core

module tb_uart_rx_core;

  localparam int C  = 16;
  localparam int H  = C / 2;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx_slow = 1'b1;
  logic [7:0] rx_data16, rx_data_s;
  logic       rx_valid16, rx_valid_s;
  logic       frame_err16, frame_err_s;
  logic       busy16, busy_s;

  always #10 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut16 (
    .clk(clk), .reset(reset), .rx_serial(rx16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .frame_err(frame_err16), .busy(busy16)
  );

  uart_rx_core dut_slow (
    .clk(clk), .reset(reset), .rx_serial(rx_slow),
    .rx_data(rx_data_s), .rx_valid(rx_valid_s), .frame_err(frame_err_s), .busy(busy_s)
  );

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;

  // Reference model state: frame timing expressed as offsets from the start edge T.
  int         cyc = 0;
  bit         seen = 0;
  bit         m_s1 = 1, m_s2 = 1;
  int         mode = 0;  // 0 idle, 1 in frame, 2 waiting for line high
  int         t_start = 0;
  logic [7:0] sh = '0;
  logic [7:0] exp_data = '0;
  bit         exp_valid = 0, exp_ferr = 0;

  // Observation log used by the hand-computed checks.
  int         nv16 = 0, nf16 = 0, bc16 = 0, nvs = 0, nfs = 0;
  int         vcyc_q[$];
  logic [7:0] vdat_q[$];
  logic [7:0] last_ds = '0;

  task automatic mcheck(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        seen = 1; m_s1 = 1; m_s2 = 1; mode = 0;
        exp_data = '0; exp_valid = 0; exp_ferr = 0;
      end else begin
        bit rxs;
        int k;
        rxs = m_s2;
        exp_valid = 0;
        exp_ferr = 0;
        case (mode)
          0: if (!rxs) begin mode = 1; t_start = cyc; end
          1: begin
            k = cyc - t_start;
            if (k == H) begin
              if (rxs) mode = 0;
            end else if (k > H && (k - H) % C == 0) begin
              int i;
              i = (k - H) / C - 1;
              if (i < DB) sh[i] = rxs;
              else if (rxs) begin exp_data = sh; exp_valid = 1; mode = 0; end
              else begin exp_ferr = 1; mode = 2; end
            end
          end
          default: if (rxs) mode = 0;
        endcase
        m_s2 = m_s1;
        m_s1 = rx16;
      end
      #1;
      if (seen) begin
        vectors++;
        mcheck("rx_data", rx_data16, exp_data);
        mcheck("rx_valid", {7'd0, rx_valid16}, {7'd0, exp_valid});
        mcheck("frame_err", {7'd0, frame_err16}, {7'd0, exp_ferr});
        mcheck("busy", {7'd0, busy16}, {7'd0, mode != 0});
        if (rx_valid16) begin nv16++; vcyc_q.push_back(cyc); vdat_q.push_back(rx_data16); end
        if (frame_err16) nf16++;
        if (busy16) bc16++;
        if (rx_valid_s) begin nvs++; last_ds = rx_data_s; end
        if (frame_err_s) nfs++;
      end
    end
  end

  task automatic drive(input bit slow, input bit v, input int n);
    if (slow) rx_slow = v; else rx16 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit slow, input logic [7:0] d, input bit stop, input int p);
    drive(slow, 1'b0, p);
    for (int i = 0; i < 8; i++) drive(slow, d[i], p);
    drive(slow, stop, p);
  endtask

  int n0, nv0, nf0;
  logic [7:0] rd;

  initial begin
    repeat (5) @(negedge clk);
    check("reset_rx_data", rx_data16, 0);
    check("reset_rx_valid", rx_valid16, 0);
    check("reset_busy", busy16, 0);
    reset = 1'b1;
    drive(0, 1, 20);

    // 0xA5 at exact timing; latency from the first edge seeing the low line.
    nv0 = nv16; nf0 = nf16; n0 = cyc + 1;
    send_frame(0, 8'hA5, 1, C);
    drive(0, 1, 20);
    check("a5_count", nv16 - nv0, 1);
    check("a5_data", vdat_q[$], 8'hA5);
    check("a5_latency", vcyc_q[$] - n0, 2 + H + 9 * C);
    check("a5_no_ferr", nf16 - nf0, 0);

    // Short glitch.
    nv0 = nv16; nf0 = nf16; bc16 = 0;
    drive(0, 0, 5);
    drive(0, 1, 30);
    check("glitch_no_valid", nv16 - nv0, 0);
    check("glitch_no_ferr", nf16 - nf0, 0);
    check("glitch_busy_cycles", bc16, 8);
    check("glitch_data", rx_data16, 8'hA5);

    // Good frame, then bad stop with line held low, then recovery.
    send_frame(0, 8'h3C, 1, C);
    drive(0, 1, 10);
    check("b_3c", rx_data16, 8'h3C);
    nf0 = nf16; nv0 = nv16;
    send_frame(0, 8'h81, 0, C);
    drive(0, 0, 40);
    check("break_ferr", nf16 - nf0, 1);
    check("break_busy", busy16, 1);
    check("break_data", rx_data16, 8'h3C);
    drive(0, 1, 30);
    check("break_idle", busy16, 0);
    check("break_no_valid", nv16 - nv0, 0);
    send_frame(0, 8'h55, 1, C);
    drive(0, 1, 10);
    check("after_break_55", rx_data16, 8'h55);

    // Back-to-back frames, no idle gap.
    send_frame(0, 8'h00, 1, C);
    send_frame(0, 8'hFF, 1, C);
    drive(0, 1, 10);
    check("b2b_gap", vcyc_q[$] - vcyc_q[$-1], 10 * C);
    check("b2b_first", vdat_q[$-1], 8'h00);
    check("b2b_second", vdat_q[$], 8'hFF);

    // Reset at bit 4 of a frame.
    nv0 = nv16; nf0 = nf16;
    drive(0, 0, C);
    for (int i = 0; i < 4; i++) drive(0, (8'hF0 >> i) & 1, C);
    drive(0, 0, H);
    rx16 = 1'b1; reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    drive(0, 1, 30);
    check("rst_no_valid", nv16 - nv0, 0);
    check("rst_no_ferr", nf16 - nf0, 0);
    check("rst_data", rx_data16, 0);
    check("rst_busy", busy16, 0);
    send_frame(0, 8'h12, 1, C);
    drive(0, 1, 10);
    check("rst_then_12", rx_data16, 8'h12);

    // Line held low through reset release.
    nf0 = nf16; nv0 = nv16;
    rx16 = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 200);
    check("lowrst_ferr", nf16 - nf0, 1);
    check("lowrst_busy", busy16, 1);
    drive(0, 1, 30);
    check("lowrst_idle", busy16, 0);
    check("lowrst_no_valid", nv16 - nv0, 0);
    check("lowrst_data", rx_data16, 0);

    // Randomized traffic checked by the cycle model.
    for (int r = 0; r < 30; r++) begin
      int kind;
      kind = $urandom_range(0, 9);
      rd = 8'($urandom);
      if (kind == 0) begin
        drive(0, 0, $urandom_range(1, 12));
        drive(0, 1, 170);
      end else if (kind == 1) begin
        send_frame(0, rd, 0, C);
        drive(0, 0, $urandom_range(0, 30));
        drive(0, 1, $urandom_range(1, 20));
      end else begin
        send_frame(0, rd, 1, C);
        drive(0, 1, $urandom_range(0, 20));
      end
    end
    drive(0, 1, 200);

    // Default bit time with +2% and -2% baud error.
    nv0 = nvs;
    check("slow_reset_data", rx_data_s, 0);
    drive(1, 1, 100);
    send_frame(1, 8'h7E, 1, 1328);
    drive(1, 1, 2000);
    check("slow_plus_count", nvs - nv0, 1);
    check("slow_plus_data", last_ds, 8'h7E);
    last_ds = '0;
    send_frame(1, 8'h7E, 1, 1276);
    drive(1, 1, 2000);
    check("slow_minus_count", nvs - nv0, 2);
    check("slow_minus_data", last_ds, 8'h7E);
    check("slow_no_ferr", nfs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
